// File: rtl/alu_pipe_pkg.sv
// Shared opcode enum, output width helper and flag bit positions for alu_pipe.
// Combinational definitions only, so no latency.
// No handshake at this level.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_INC  = 4'd9,
    OP_DEC  = 4'd10,
    OP_PASS = 4'd11,
    OP_CMP  = 4'd12,
    OP_NAND = 4'd13,
    OP_NOR  = 4'd14,
    OP_XNOR = 4'd15
  } alu_op_e;

  function automatic int out_w(input int width);
    return 2 * width;
  endfunction

  localparam int FLAGS_W    = 3;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe; flags port exists only with ALU_FLAGS_EN.
// Wires only, so no latency.
// Valid/ready in both directions; master drives operands and out_ready.
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         s;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic [TAG_W-1:0]   out_tag;
`ifdef ALU_FLAGS_EN
  logic [FLAGS_W-1:0] flags;
`endif

  modport master (
`ifdef ALU_FLAGS_EN
    input  flags,
`endif
    output in_valid, a, b, s, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag
  );

  modport slave (
`ifdef ALU_FLAGS_EN
    output flags,
`endif
    input  in_valid, a, b, s, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag
  );
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational opcode -> 2*WIDTH result function; flags only with ALU_FLAGS_EN.
// Zero latency.
// No handshake; sits between the S1 and S2 registers.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [3:0]              s,
`ifdef ALU_FLAGS_EN
  output logic [FLAGS_W-1:0]      flags,
`endif
  output logic [out_w(WIDTH)-1:0] res
);
  localparam int OW = out_w(WIDTH);
  localparam logic [OW-1:0] OW_V = OW'(OW);
  localparam logic [OW-1:0] ONE  = OW'(1);

  logic [OW-1:0] ax, bx;

  assign ax = {{WIDTH{1'b0}}, a};
  assign bx = {{WIDTH{1'b0}}, b};

  always_comb begin
    res = '0;
    case (alu_op_e'(s))
      OP_ADD:  res = ax + bx;
      OP_SUB:  res = ax - bx;
      OP_MUL:  res = ax * bx;
      OP_AND:  res = {{WIDTH{1'b0}}, a & b};
      OP_OR:   res = {{WIDTH{1'b0}}, a | b};
      OP_XOR:  res = {{WIDTH{1'b0}}, a ^ b};
      OP_NOT:  res = {{WIDTH{1'b0}}, ~a};
      // The whole of b is the shift amount, so oversize shifts must flush to zero.
      OP_SHL:  res = (bx >= OW_V) ? '0 : (ax << bx);
      OP_SHR:  res = (bx >= OW_V) ? '0 : (ax >> bx);
      OP_INC:  res = ax + ONE;
      OP_DEC:  res = ax - ONE;
      OP_PASS: res = ax;
      OP_CMP:  res = {{(OW-3){1'b0}}, a < b, a == b, a > b};
      OP_NAND: res = {{WIDTH{1'b0}}, ~(a & b)};
      OP_NOR:  res = {{WIDTH{1'b0}}, ~(a | b)};
      OP_XNOR: res = {{WIDTH{1'b0}}, ~(a ^ b)};
      default: res = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    flags            = '0;
    flags[FLAG_ZERO] = (res == '0);
    flags[FLAG_NEG]  = res[WIDTH-1];
    case (alu_op_e'(s))
      OP_ADD, OP_INC: flags[FLAG_CARRY] = res[WIDTH];
      OP_SUB:         flags[FLAG_CARRY] = (a < b);
      OP_DEC:         flags[FLAG_CARRY] = (a == '0);
      default:        flags[FLAG_CARRY] = 1'b0;
    endcase
  end
`endif
endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with tag pass-through; optional flags output under ALU_FLAGS_EN.
// Result valid two edges after the cycle an op is presented; one op per cycle.
// Holds up to two ops under backpressure; in_ready falls only when both stages are stalled.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);
  localparam int OW = out_w(WIDTH);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [3:0]       s1_s;
  logic [TAG_W-1:0] s1_tag;
  logic [OW-1:0]    core_res;
  logic             s1_adv, s2_adv;
`ifdef ALU_FLAGS_EN
  logic [FLAGS_W-1:0] core_flags;
`endif

  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv && !rst;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .s     (s1_s),
`ifdef ALU_FLAGS_EN
    .flags (core_flags),
`endif
    .res   (core_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.out_tag   <= '0;
`ifdef ALU_FLAGS_EN
      bus.flags     <= '0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a   <= bus.a;
          s1_b   <= bus.b;
          s1_s   <= bus.s;
          s1_tag <= bus.in_tag;
        end
      end
      // Payload only moves with a valid op, so a stalled or idle output keeps its last value.
      if (s2_adv) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out     <= core_res;
          bus.out_tag <= s1_tag;
`ifdef ALU_FLAGS_EN
          bus.flags   <= core_flags;
`endif
        end
      end
    end
  end
endmodule
